// File: rtl/glyph_plotter.sv
// Serialises one latched 8x16 glyph into per-pixel framebuffer writes in raster order,
// with downstream back-pressure and an optional transparent background.
module glyph_plotter #(
    parameter int X_BITS      = 9,
    parameter int Y_BITS      = 8,
    parameter int COLOUR_BITS = 3,
    parameter int TRANSPARENT = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [127:0]           glyph_pixels,
    input  logic [X_BITS-1:0]      origin_x,
    input  logic [Y_BITS-1:0]      origin_y,
    input  logic [COLOUR_BITS-1:0] fg_colour,
    input  logic [COLOUR_BITS-1:0] bg_colour,
    input  logic                   plot_ready,
    output logic [X_BITS-1:0]      x,
    output logic [Y_BITS-1:0]      y,
    output logic [COLOUR_BITS-1:0] colour,
    output logic                   plot,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [6:0]             idx;

    logic [127:0]           glyph_q;
    logic [X_BITS-1:0]      ox_q;
    logic [Y_BITS-1:0]      oy_q;
    logic [COLOUR_BITS-1:0] fg_q;
    logic [COLOUR_BITS-1:0] bg_q;

    logic [127:0]           src_glyph;
    logic [X_BITS-1:0]      src_ox;
    logic [Y_BITS-1:0]      src_oy;
    logic [COLOUR_BITS-1:0] src_fg;
    logic [COLOUR_BITS-1:0] src_bg;
    logic [6:0]             src_idx;
    logic                   src_bit;
    logic [X_BITS-1:0]      next_x;
    logic [Y_BITS-1:0]      next_y;
    logic [COLOUR_BITS-1:0] next_colour;
    logic                   next_plot;
    logic                   advance;

    function automatic logic glyph_bit(input logic [127:0] g, input logic [6:0] i);
        return g[7'd127 - i];
    endfunction

    function automatic logic [X_BITS-1:0] wrap_x(input logic [X_BITS-1:0] o, input logic [2:0] c);
        return o + X_BITS'(c);
    endfunction

    function automatic logic [Y_BITS-1:0] wrap_y(input logic [Y_BITS-1:0] o, input logic [3:0] r);
        return o + Y_BITS'(r);
    endfunction

    // The pixel to present next: pixel 0 straight from the inputs on an accepted start,
    // otherwise the following pixel of the latched glyph. Outputs are always registered.
    always_comb begin
        if (state == IDLE) begin
            src_glyph = glyph_pixels;
            src_ox    = origin_x;
            src_oy    = origin_y;
            src_fg    = fg_colour;
            src_bg    = bg_colour;
            src_idx   = 7'd0;
        end else begin
            src_glyph = glyph_q;
            src_ox    = ox_q;
            src_oy    = oy_q;
            src_fg    = fg_q;
            src_bg    = bg_q;
            src_idx   = idx + 7'd1;
        end
        src_bit     = glyph_bit(src_glyph, src_idx);
        next_x      = wrap_x(src_ox, src_idx[2:0]);
        next_y      = wrap_y(src_oy, src_idx[6:3]);
        next_colour = src_bit ? src_fg : src_bg;
        next_plot   = src_bit || (TRANSPARENT == 0);
        advance     = (state == DRAW) && (plot_ready || !plot);
    end

    always_ff @(posedge clock) begin
        if (state == IDLE && start) begin
            glyph_q <= glyph_pixels;
            ox_q    <= origin_x;
            oy_q    <= origin_y;
            fg_q    <= fg_colour;
            bg_q    <= bg_colour;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= 7'd0;
            plot   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    plot <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        state  <= DRAW;
                        idx    <= 7'd0;
                        busy   <= 1'b1;
                        plot   <= next_plot;
                        x      <= next_x;
                        y      <= next_y;
                        colour <= next_colour;
                    end
                end
                DRAW: begin
                    if (advance) begin
                        if (idx == 7'd127) begin
                            state <= DONE;
                            plot  <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            idx    <= idx + 7'd1;
                            plot   <= next_plot;
                            x      <= next_x;
                            y      <= next_y;
                            colour <= next_colour;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    plot  <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_glyph_plotter.sv
// Directed bench for glyph_plotter: an opaque and a transparent instance share stimulus,
// expected pixels are queued at start and popped as writes are accepted.
module tb_glyph_plotter;

    localparam int XB = 9;
    localparam int YB = 8;
    localparam int CB = 3;

    logic          clk;
    logic          rst;
    logic          start0;
    logic          start1;
    logic          plot_ready;
    logic [127:0]  glyph;
    logic [XB-1:0] ox;
    logic [YB-1:0] oy;
    logic [CB-1:0] fg;
    logic [CB-1:0] bg;

    logic [XB-1:0] x0, x1;
    logic [YB-1:0] y0, y1;
    logic [CB-1:0] c0, c1;
    logic          plot0, plot1, busy0, busy1, done0, done1;

    typedef struct packed {
        logic [XB-1:0] x;
        logic [YB-1:0] y;
        logic [CB-1:0] c;
    } pix_t;

    pix_t q0[$];
    pix_t q1[$];
    pix_t first0, last0, first1, last1;
    pix_t got0, got1, exp0, exp1;
    logic [7:0] rows[16];

    int checks = 0;
    int errors = 0;
    int plots0 = 0, plots1 = 0, dones0 = 0, dones1 = 0;
    logic        hold_pend0 = 1'b0, hold_pend1 = 1'b0;
    logic [20:0] hold_val0, hold_val1;

    glyph_plotter #(.X_BITS(XB), .Y_BITS(YB), .COLOUR_BITS(CB), .TRANSPARENT(0)) dut0 (
        .clock(clk), .reset(rst), .start(start0), .glyph_pixels(glyph),
        .origin_x(ox), .origin_y(oy), .fg_colour(fg), .bg_colour(bg),
        .plot_ready(plot_ready), .x(x0), .y(y0), .colour(c0),
        .plot(plot0), .busy(busy0), .done(done0)
    );

    glyph_plotter #(.X_BITS(XB), .Y_BITS(YB), .COLOUR_BITS(CB), .TRANSPARENT(1)) dut1 (
        .clock(clk), .reset(rst), .start(start1), .glyph_pixels(glyph),
        .origin_x(ox), .origin_y(oy), .fg_colour(fg), .bg_colour(bg),
        .plot_ready(plot_ready), .x(x1), .y(y1), .colour(c1),
        .plot(plot1), .busy(busy1), .done(done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold_pend0 = 1'b0;
        end else begin
            if (hold_pend0) chk("hold0", {x0, y0, c0, plot0}, hold_val0);
            hold_pend0 = plot0 && !plot_ready;
            hold_val0  = {x0, y0, c0, plot0};
            if (done0) dones0++;
            if (plot0 && plot_ready) begin
                got0 = '{x: x0, y: y0, c: c0};
                if (plots0 == 0) first0 = got0;
                last0 = got0;
                plots0++;
                if (q0.size() == 0) chk("extra_plot0", 1, 0);
                else begin
                    exp0 = q0.pop_front();
                    chk("pixel0", got0, exp0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            hold_pend1 = 1'b0;
        end else begin
            if (hold_pend1) chk("hold1", {x1, y1, c1, plot1}, hold_val1);
            hold_pend1 = plot1 && !plot_ready;
            hold_val1  = {x1, y1, c1, plot1};
            if (done1) dones1++;
            if (plot1 && plot_ready) begin
                got1 = '{x: x1, y: y1, c: c1};
                if (plots1 == 0) first1 = got1;
                last1 = got1;
                plots1++;
                if (q1.size() == 0) chk("extra_plot1", 1, 0);
                else begin
                    exp1 = q1.pop_front();
                    chk("pixel1", got1, exp1);
                end
            end
        end
    end

    task automatic load_a_glyph();
        for (int r = 0; r < 16; r++) rows[r] = 8'h00;
        for (int r = 2; r <= 4; r++) rows[r] = 8'b00111000;
        for (int r = 5; r <= 7; r++) rows[r] = 8'b01101100;
        rows[8] = 8'b01111100;
        for (int r = 9; r <= 11; r++) rows[r] = 8'b11000110;
        glyph = '0;
        for (int r = 0; r < 16; r++) glyph = {glyph[119:0], rows[r]};
    endtask

    task automatic push_expect(input bit which);
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 8; c++) begin
                pix_t p;
                bit   b;
                b   = rows[r][7-c];
                p.x = XB'((int'(ox) + c) % (1 << XB));
                p.y = YB'((int'(oy) + r) % (1 << YB));
                p.c = b ? fg : bg;
                if (which) begin
                    if (b) q1.push_back(p);
                end else begin
                    q0.push_back(p);
                end
            end
        end
    endtask

    function automatic logic ready_for(input int mode, input int n);
        if (mode != 1) return 1'b1;
        if (n >= 6 && n <= 8) return 1'b0;
        if (n >= 44 && n <= 62 && (n % 2) == 0) return 1'b0;
        return 1'b1;
    endfunction

    // mode: 0 plain, 1 back-pressure, 2 stray start pulses, 3 reset at pixel 60
    task automatic draw(input bit which, input int mode, input int exp_plots, input int exp_done);
        int done_at;
        done_at = 0;
        push_expect(which);
        plots0 = 0; plots1 = 0; dones0 = 0; dones1 = 0;
        plot_ready = 1'b1;
        if (which) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        for (int n = 1; n <= 400 && done_at == 0; n++) begin
            plot_ready = ready_for(mode, n);
            start0 = (mode == 2) && (n == 50 || n == 129);
            @(negedge clk);
            if (mode == 3 && n == 61) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_plot", plot0, 0);
                chk("rst_busy", busy0, 0);
                chk("rst_done", done0, 0);
                chk("rst_xyc", {x0, y0, c0}, 0);
                q0.delete();
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                plot_ready = 1'b1;
                start0 = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                chk("rst_no_done", dones0, 0);
                chk("rst_idle_busy", busy0, 0);
                return;
            end
            if (which ? done1 : done0) begin
                done_at = n;
                chk("busy_at_done", which ? busy1 : busy0, 0);
            end else if (mode == 2 && n <= 128) begin
                chk("busy_draw", busy0, 1);
            end
            @(posedge clk);
            #1;
        end
        start0 = 1'b0;
        plot_ready = 1'b1;
        if (done_at == 0) chk("done_timeout", 0, 1);
        chk("done_cycle", done_at, exp_done);
        repeat (3) @(posedge clk);
        #1;
        chk("plots", which ? plots1 : plots0, exp_plots);
        chk("done_pulses", which ? dones1 : dones0, 1);
        chk("queue_empty", which ? q1.size() : q0.size(), 0);
        chk("idle_busy", which ? busy1 : busy0, 0);
        chk("idle_plot", which ? plot1 : plot0, 0);
    endtask

    initial begin
        rst = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        plot_ready = 1'b1;
        ox = '0; oy = '0; fg = '0; bg = '0;
        load_a_glyph();
        #3;
        chk("reset_outs0", {x0, y0, c0, plot0, busy0, done0}, 0);
        chk("reset_outs1", {x1, y1, c1, plot1, busy1, done1}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        ox = 9'd10; oy = 8'd20; fg = 3'd7; bg = 3'd0;
        draw(1'b0, 0, 128, 129);
        chk("first_opaque", first0, {9'd10, 8'd20, 3'd0});
        chk("last_opaque", last0, {9'd17, 8'd35, 3'd0});

        draw(1'b1, 0, 38, 129);
        chk("first_transp", first1, {9'd12, 8'd22, 3'd7});

        draw(1'b0, 1, 128, 142);

        ox = 9'd510; oy = 8'd250; fg = 3'd5; bg = 3'd2;
        draw(1'b0, 0, 128, 129);
        chk("wrap_first", first0, {9'd510, 8'd250, 3'd2});
        chk("wrap_last", last0, {9'd5, 8'd9, 3'd2});

        ox = 9'd100; oy = 8'd50; fg = 3'd3; bg = 3'd4;
        draw(1'b0, 2, 128, 129);

        draw(1'b0, 3, 0, 0);
        ox = 9'd30; oy = 8'd40; fg = 3'd6; bg = 3'd1;
        draw(1'b0, 0, 128, 129);
        chk("after_rst_first", first0, {9'd30, 8'd40, 3'd1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
